// File: rtl/aux_arb_pkg.sv
// rtl/aux_arb_pkg.sv - shared types and constants for the AUX channel arbiter
package aux_arb_pkg;

    localparam int AW          = 20;
    localparam int DW          = 8;
    localparam int DEF_TIMEOUT = 65535;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_LOCKED  = 2'd3
    } state_t;

    function automatic int rr_next(input int last, input int step, input int n);
        return (last + step) % n;
    endfunction

endpackage

// File: rtl/aux_arb_if.sv
// rtl/aux_arb_if.sv - requester and AUX master signal bundle for aux_arb
interface aux_arb_if #(
    parameter int NREQ = 2
);
    import aux_arb_pkg::*;

    logic [NREQ-1:0]    rreq;
    logic [NREQ-1:0]    rwr;
    logic [AW*NREQ-1:0] raddr;
    logic [DW*NREQ-1:0] rwdata;
    logic [NREQ-1:0]    rlock;
    logic [NREQ-1:0]    rack;
    logic               rerr;
    logic [DW-1:0]      rrdata;
    logic [NREQ-1:0]    grant;
    logic [AW-1:0]      auxaddr;
    logic [DW-1:0]      auxwdata;
    logic               auxwr;
    logic               auxreq;
    logic               auxack;
    logic               auxerr;
    logic [DW-1:0]      auxrdata;

    modport slave (
        input  rreq, rwr, raddr, rwdata, rlock, auxack, auxerr, auxrdata,
        output rack, rerr, rrdata, grant, auxaddr, auxwdata, auxwr, auxreq
    );

    modport master (
        output rreq, rwr, raddr, rwdata, rlock, auxack, auxerr, auxrdata,
        input  rack, rerr, rrdata, grant, auxaddr, auxwdata, auxwr, auxreq
    );

endinterface

// File: rtl/aux_arb_rr_pick.sv
// rtl/aux_arb_rr_pick.sv - combinational round-robin picker starting after the last owner
module rr_pick
    import aux_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_last,
    output logic [NREQ-1:0] o_grant,
    output logic [IW-1:0]   o_idx,
    output logic            o_any
);

    // Walk offsets from farthest to nearest so the nearest requester after i_last wins.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = |i_req;
        for (int k = NREQ; k >= 1; k--) begin
            for (int i = 0; i < NREQ; i++) begin
                if (i == rr_next(int'(i_last), k, NREQ) && i_req[i]) begin
                    o_grant    = '0;
                    o_grant[i] = 1'b1;
                    o_idx      = IW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/aux_arb.sv
// rtl/aux_arb.sv - round-robin arbiter with lock and timeout for the shared AUX master
module aux_arb
    import aux_arb_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int TW      = 16
) (
    input  logic     clk,
    input  logic     resetn,
    aux_arb_if.slave bus
);

    localparam int            IW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    state_t          r_state;
    logic [IW-1:0]   r_last;
    logic [IW-1:0]   r_g;
    logic [TW-1:0]   r_cnt;
    logic [NREQ-1:0] r_grant;
    logic [NREQ-1:0] r_rack;
    logic            r_rerr;
    logic [DW-1:0]   r_rrdata;
    logic [AW-1:0]   r_auxaddr;
    logic [DW-1:0]   r_auxwdata;
    logic            r_auxwr;
    logic            r_auxreq;

    logic [NREQ-1:0] w_pick_grant;
    logic [IW-1:0]   w_pick_idx;
    logic            w_pick_any;
    logic [IW-1:0]   w_sel;
    logic [NREQ-1:0] w_sel_grant;
    logic            w_issue;
    logic [AW-1:0]   w_addr;
    logic [DW-1:0]   w_wdata;
    logic            w_wr;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .i_req   (bus.rreq),
        .i_last  (r_last),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    // A locked owner reissues without arbitration; otherwise the picker chooses.
    always_comb begin
        w_sel       = (r_state == ST_IDLE) ? w_pick_idx : r_g;
        w_sel_grant = (r_state == ST_IDLE) ? w_pick_grant : r_grant;
        w_issue     = ((r_state == ST_IDLE) && w_pick_any) ||
                      ((r_state == ST_LOCKED) && bus.rreq[r_g]);
        w_addr      = '0;
        w_wdata     = '0;
        w_wr        = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_sel == IW'(i)) begin
                w_addr  = bus.raddr[i*AW +: AW];
                w_wdata = bus.rwdata[i*DW +: DW];
                w_wr    = bus.rwr[i];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_last     <= '0;
            r_g        <= '0;
            r_cnt      <= '0;
            r_grant    <= '0;
            r_rack     <= '0;
            r_rerr     <= 1'b0;
            r_rrdata   <= '0;
            r_auxaddr  <= '0;
            r_auxwdata <= '0;
            r_auxwr    <= 1'b0;
            r_auxreq   <= 1'b0;
        end else begin
            r_rack <= '0;
            case (r_state)
                ST_IDLE, ST_LOCKED: begin
                    if (w_issue) begin
                        r_g        <= w_sel;
                        r_grant    <= w_sel_grant;
                        r_auxaddr  <= w_addr;
                        r_auxwdata <= w_wdata;
                        r_auxwr    <= w_wr;
                        r_auxreq   <= 1'b1;
                        r_cnt      <= '0;
                        r_state    <= ST_BUSY;
                    end else if (r_state == ST_LOCKED && !bus.rlock[r_g]) begin
                        r_last  <= r_g;
                        r_grant <= '0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    // An ack arriving on the timeout cycle takes priority over the timeout.
                    if (bus.auxack) begin
                        r_auxreq <= 1'b0;
                        r_rack   <= r_grant;
                        r_rerr   <= bus.auxerr;
                        r_rrdata <= bus.auxrdata;
                        r_state  <= ST_RELEASE;
                    end else if (r_cnt == TO_LAST) begin
                        r_auxreq <= 1'b0;
                        r_rack   <= r_grant;
                        r_rerr   <= 1'b1;
                        r_rrdata <= '0;
                        r_state  <= ST_RELEASE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (!bus.rreq[r_g]) begin
                        if (bus.rlock[r_g]) begin
                            r_state <= ST_LOCKED;
                        end else begin
                            r_last  <= r_g;
                            r_grant <= '0;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.rack     = r_rack;
    assign bus.rerr     = r_rerr;
    assign bus.rrdata   = r_rrdata;
    assign bus.grant    = r_grant;
    assign bus.auxaddr  = r_auxaddr;
    assign bus.auxwdata = r_auxwdata;
    assign bus.auxwr    = r_auxwr;
    assign bus.auxreq   = r_auxreq;

endmodule

// File: tb/tb_aux_arb.sv
// tb/tb_aux_arb.sv - scoreboard bench for aux_arb
module tb_aux_arb;
    import aux_arb_pkg::*;

    localparam int NREQ = 2;
    localparam int TO   = 16;

    logic clk    = 1'b0;
    logic resetn = 1'b1;

    always #5 clk = ~clk;

    aux_arb_if #(.NREQ(NREQ)) bus ();

    aux_arb #(
        .NREQ    (NREQ),
        .TIMEOUT (TO),
        .TW      (16)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        logic       err;
        logic [7:0] data;
    } rsp_t;

    typedef struct {
        logic [19:0] addr;
        logic        wr;
        logic [7:0]  wdata;
    } aux_t;

    int   checks = 0;
    int   errors = 0;
    rsp_t exp_rsp[NREQ][$];
    aux_t exp_aux[$];

    int         ack_delay = 0;
    logic       ack_err   = 1'b0;
    logic [7:0] ack_data  = 8'h00;
    bit         handled   = 1'b0;
    logic       prev_auxreq = 1'b0;
    int         mon_p;
    rsp_t       mon_e;
    aux_t       mon_a;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_aux(input logic [19:0] a, input logic w, input logic [7:0] d);
        aux_t t;
        t.addr = a; t.wr = w; t.wdata = d;
        exp_aux.push_back(t);
    endtask

    // Requester model: raise request, hold until rack, drop one cycle later.
    task automatic txn(input int p, input logic [19:0] a, input logic w, input logic [7:0] d,
                       input logic e_err, input logic [7:0] e_data);
        rsp_t r;
        int   n;
        r.err = e_err; r.data = e_data;
        exp_rsp[p].push_back(r);
        bus.raddr[p*20 +: 20] = a;
        bus.rwdata[p*8 +: 8]  = d;
        bus.rwr[p]            = w;
        bus.rreq[p]           = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.rack[p] && n < 300);
        if (!bus.rack[p]) begin
            checks++;
            errors++;
            $display("FAIL txn_wait port %0d: no rack within 300 cycles", p);
        end
        @(posedge clk); #1;
        bus.rreq[p] = 1'b0;
    endtask

    // AUX master model: acks ack_delay cycles after auxreq rises (0 = never).
    initial begin
        bus.auxack   = 1'b0;
        bus.auxerr   = 1'b0;
        bus.auxrdata = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (!bus.auxreq) begin
                handled = 1'b0;
            end else if (!handled && ack_delay > 0) begin
                handled = 1'b1;
                for (int k = 1; k < ack_delay; k++) @(posedge clk);
                #1;
                bus.auxack   = 1'b1;
                bus.auxerr   = ack_err;
                bus.auxrdata = ack_data;
                @(posedge clk); #1;
                bus.auxack   = 1'b0;
                bus.auxerr   = 1'b0;
                bus.auxrdata = 8'h00;
            end
        end
    end

    // Response monitor
    always @(negedge clk) begin
        if (resetn && bus.rack != '0) begin
            chk("rack_onehot", 32'($onehot(bus.rack)), 32'd1);
            mon_p = 0;
            for (int i = 0; i < NREQ; i++) if (bus.rack[i]) mon_p = i;
            if (exp_rsp[mon_p].size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rack: rack=%b with no response outstanding", bus.rack);
            end else begin
                mon_e = exp_rsp[mon_p].pop_front();
                chk("rerr", 32'(bus.rerr), 32'(mon_e.err));
                chk("rrdata", 32'(bus.rrdata), 32'(mon_e.data));
            end
        end
    end

    // AUX request monitor: order and content of forwarded transactions
    always @(negedge clk) begin
        if (bus.auxreq && !prev_auxreq) begin
            if (exp_aux.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_auxreq: addr=%0h", bus.auxaddr);
            end else begin
                mon_a = exp_aux.pop_front();
                chk("auxaddr", 32'(bus.auxaddr), 32'(mon_a.addr));
                chk("auxwr", 32'(bus.auxwr), 32'(mon_a.wr));
                chk("auxwdata", 32'(bus.auxwdata), 32'(mon_a.wdata));
            end
        end
        prev_auxreq = bus.auxreq;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int m;
        bus.rreq = '0; bus.rwr = '0; bus.raddr = '0; bus.rwdata = '0; bus.rlock = '0;
        resetn = 1'b0;
        #1;
        chk("reset_grant", 32'(bus.grant), 32'd0);
        chk("reset_auxreq", 32'(bus.auxreq), 32'd0);
        chk("reset_rack", 32'(bus.rack), 32'd0);
        chk("reset_rerr", 32'(bus.rerr), 32'd0);
        chk("reset_rrdata", 32'(bus.rrdata), 32'd0);
        chk("reset_auxaddr", 32'(bus.auxaddr), 32'd0);
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk); #1;

        // Single read
        ack_delay = 5; ack_data = 8'hA5; ack_err = 1'b0;
        push_aux(20'h00202, 1'b0, 8'h00);
        fork
            txn(0, 20'h00202, 1'b0, 8'h00, 1'b0, 8'hA5);
            begin
                chk("pre_auxreq", 32'(bus.auxreq), 32'd0);
                @(posedge clk); #1;
                chk("auxreq_latency", 32'(bus.auxreq), 32'd1);
                chk("single_grant", 32'(bus.grant), 32'd1);
            end
        join
        repeat (2) @(posedge clk); #1;
        chk("single_grant_idle", 32'(bus.grant), 32'd0);

        // Contention: port 1 first each round, then port 0
        ack_delay = 2; ack_data = 8'h11;
        for (int r = 0; r < 4; r++) begin
            push_aux(20'h00110 + 20'(r), 1'b1, 8'h10 + 8'(r));
            push_aux(20'h00010 + 20'(r), 1'b1, 8'h20 + 8'(r));
            fork
                txn(1, 20'h00110 + 20'(r), 1'b1, 8'h10 + 8'(r), 1'b0, 8'h11);
                txn(0, 20'h00010 + 20'(r), 1'b1, 8'h20 + 8'(r), 1'b0, 8'h11);
            join
            repeat (2) @(posedge clk); #1;
        end

        // Lock: port 1 runs three writes while port 0 waits
        ack_delay = 3; ack_data = 8'h22;
        for (int i = 0; i < 3; i++) push_aux(20'h00100 + 20'(i), 1'b1, 8'h30 + 8'(i));
        push_aux(20'h00300, 1'b0, 8'h00);
        fork
            txn(0, 20'h00300, 1'b0, 8'h00, 1'b0, 8'h22);
            begin
                bus.rlock[1] = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    txn(1, 20'h00100 + 20'(i), 1'b1, 8'h30 + 8'(i), 1'b0, 8'h22);
                    if (i < 2) begin
                        @(posedge clk); #1;
                    end
                end
                bus.rlock[1] = 1'b0;
                n = 0;
                while (bus.grant != 2'b01 && n < 10) begin
                    @(posedge clk); #1;
                    n++;
                end
                chk("lock_release_cycles_le2", 32'(n <= 2), 32'd1);
            end
        join
        repeat (2) @(posedge clk); #1;

        // Timeout with a late ack at cycle 20
        ack_delay = 20;
        push_aux(20'h00400, 1'b0, 8'h00);
        fork
            txn(0, 20'h00400, 1'b0, 8'h00, 1'b1, 8'h00);
            begin
                m = 0;
                while (!bus.auxreq && m < 10) begin
                    @(posedge clk); #1;
                    m++;
                end
                n = 0;
                while (bus.auxreq && n < 40) begin
                    @(posedge clk); #1;
                    n++;
                end
                chk("timeout_auxreq_cycles", 32'(n), 32'(TO));
            end
        join
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("late_ack_no_rack", 32'(bus.rack), 32'd0);
        end
        @(posedge clk); #1;

        // Ack on the timeout cycle wins
        ack_delay = TO; ack_data = 8'h3C; ack_err = 1'b0;
        push_aux(20'h00500, 1'b1, 8'h5A);
        txn(0, 20'h00500, 1'b1, 8'h5A, 1'b0, 8'h3C);
        repeat (2) @(posedge clk); #1;

        // Asynchronous reset during BUSY
        ack_delay = 0;
        push_aux(20'h00600, 1'b0, 8'h00);
        bus.raddr[20 +: 20] = 20'h00600;
        bus.rwr[1]  = 1'b0;
        bus.rwdata[8 +: 8] = 8'h00;
        bus.rreq[1] = 1'b1;
        m = 0;
        while (!bus.auxreq && m < 10) begin
            @(posedge clk); #1;
            m++;
        end
        chk("busy_before_reset", 32'(bus.auxreq), 32'd1);
        repeat (3) @(posedge clk);
        #3 resetn = 1'b0;
        #1;
        chk("async_reset_auxreq", 32'(bus.auxreq), 32'd0);
        chk("async_reset_grant", 32'(bus.grant), 32'd0);
        chk("async_reset_rack", 32'(bus.rack), 32'd0);
        bus.rreq[1] = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        ack_delay = 4; ack_data = 8'h77;
        push_aux(20'h00700, 1'b0, 8'h00);
        txn(0, 20'h00700, 1'b0, 8'h00, 1'b0, 8'h77);
        repeat (5) @(posedge clk); #1;

        chk("aux_queue_empty", 32'(exp_aux.size()), 32'd0);
        for (int p = 0; p < NREQ; p++) chk("rsp_queue_empty", 32'(exp_rsp[p].size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aux_arb.md
Name: aux_arb

Overview:
- Arbitrates the shared DisplayPort AUX channel master between NREQ requesters: the register block (port 0) and the link-training / HPD sequencer (port 1).
- Forwards one byte transaction at a time from the granted requester to the AUX master and returns ack/err/rdata to that requester.
- Provides round-robin fairness, a per-requester lock for multi-transaction sequences, and a response timeout.

Parameters:
NREQ, 2, number of requesters (2..4)
TIMEOUT, 65535, cycles allowed between auxreq rise and auxack before an error completion
TW, 16, timeout counter width; must satisfy TIMEOUT < 2**TW

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
rreq  in  NREQ  per-requester request level; held high until the matching rack
rwr  in  NREQ  per-requester write (1) / read (0)
raddr  in  20*NREQ  per-requester AUX address; slice i = [20*i +: 20]
rwdata  in  8*NREQ  per-requester write byte
rlock  in  NREQ  keep grant after completion while high
rack  out  NREQ  one-cycle completion pulse to the granted requester
rerr  out  1  error status, valid with rack
rrdata  out  8  read byte, valid with rack
grant  out  NREQ  one-hot current owner; 0 when idle
auxaddr  out  20  to AUX master
auxwdata  out  8  to AUX master
auxwr  out  1  to AUX master
auxreq  out  1  to AUX master; level, held until auxack or timeout
auxack  in  1  AUX master completion pulse
auxerr  in  1  AUX master error, valid with auxack
auxrdata  in  8  AUX master read byte, valid with auxack

Behaviour:
- Reset (resetn low, asynchronous): all outputs 0, state IDLE, rr pointer 0, timeout counter 0.
- States: IDLE, BUSY, RELEASE, LOCKED.
- IDLE: if any rreq, select a winner g round-robin, searching from (last+1) mod NREQ upward. On that edge:
  - grant <= onehot(g); auxaddr/auxwdata/auxwr <= slice g; auxreq <= 1; counter <= 0; go to BUSY.
  - Latency: rreq high at edge n gives auxreq high after edge n+1.
- BUSY: aux* outputs are stable; counter increments each cycle.
  - auxack: auxreq <= 0; rack[g] <= 1 for one cycle; rerr <= auxerr; rrdata <= auxrdata; go to RELEASE.
  - Else counter == TIMEOUT-1: auxreq <= 0; rack[g] pulse; rerr <= 1; rrdata <= 0; go to RELEASE.
  - auxack on the timeout cycle: auxack wins.
- RELEASE: wait for rreq[g] == 0; a requester may hold req one cycle past ack. Then:
  - rlock[g] high: go to LOCKED with grant kept.
  - Otherwise: last <= g; grant <= 0; go to IDLE.
- LOCKED: other requesters are starved.
  - rreq[g]: issue as in IDLE without arbitration; go to BUSY.
  - Else !rlock[g]: last <= g; grant <= 0; go to IDLE.
- auxack outside BUSY (for example a late ack after a timeout) is ignored; no rack.
- rreq[g] dropped during BUSY: the transaction still completes and rack still pulses (tolerated protocol violation).
- Inputs from non-granted requesters are ignored. rack is never asserted on more than one bit.
- rerr and rrdata hold their value until the next completion.

Decomposition:
- dport.vh: state encodings (`AUXARB_IDLE..`), AUX address width 20, default TIMEOUT.
- Sub-module rr_pick: combinational round-robin picker (req vector, last index -> one-hot winner and index).
- The FSM, output registers and counter stay in aux_arb.

Test Plan:
- Single read: rreq=01, raddr0=0x00202. AUX master acks after 5 cycles with auxrdata=0xA5, auxerr=0. Required: auxreq high 1 cycle after rreq; rack=01 for one cycle; rrdata=A5; rerr=0; grant returns to 00.
- Contention: rreq=11 raised together, last=0 after reset. Required: port 1 served first, then port 0. Repeat 4 times: grants strictly alternate.
- Lock: port 1 issues 3 writes (0x00100..0x00102) with rlock[1]=1 while rreq[0] is high. Required: all 3 complete before port 0 is granted. Port 0 is granted within 2 cycles of rlock[1] falling.
- Timeout: TIMEOUT=16, AUX master never acks. Required: auxreq falls exactly 16 cycles after rising; rack pulses with rerr=1, rrdata=00. A late auxack at cycle 20 produces no rack.
- Ack/timeout collision: auxack with auxerr=0 on cycle TIMEOUT-1. Required: rerr=0 and rrdata=auxrdata.
- Async reset in BUSY: resetn low mid-transaction. Required: auxreq, grant and rack are 0 immediately, without a clock edge. After release, a new rreq restarts arbitration normally.
